// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared types and constants for the instruction prefetch buffer.
package prefetch_pkg;
    localparam int DEFAULT_DEPTH = 4;
    localparam logic [31:0] NOP_INSN = 32'd0;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } entry_t;
endpackage

// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if: imem fetch, redirect and decode handshake signals of the prefetcher.
interface instr_prefetch_if;
    logic [31:0] address_imem;
    logic [31:0] q_imem;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        insn_valid;
    logic [31:0] insn_out;
    logic [31:0] insn_pc;
    logic        insn_ready;
    modport master (
        output address_imem, insn_valid, insn_out, insn_pc,
        input  q_imem, redirect, redirect_pc, insn_ready
    );
    modport slave (
        input  address_imem, insn_valid, insn_out, insn_pc,
        output q_imem, redirect, redirect_pc, insn_ready
    );
endinterface

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: entry storage, wrapping pointers and occupancy count with flush.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        din,
    output entry_t        head,
    output logic [CW-1:0] count
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    entry_t mem [DEPTH];

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end

    always_ff @(posedge clock)
        if (push && !flush) mem[wr_ptr] <= din;

    assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: fetch-address control feeding a small instruction FIFO toward decode.
// Optional PREFETCH_BYPASS_EN forwards the returning imem word when the FIFO is empty.
module instr_prefetch
    import prefetch_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'd0,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    instr_prefetch_if.master     bus,
    output logic [CW-1:0]        count
);
    logic [31:0] fetch_pc, pending_pc;
    logic        pending, issue, push, fifo_pop;
    entry_t      head, cur, incoming;

    // A slot is reserved for the in-flight word, so a push never lands on a full FIFO.
    assign issue = (int'(count) + int'(pending) < DEPTH) && !bus.redirect;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            fetch_pc   <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= '0;
        end else begin
            pending  <= issue;
            if (issue) pending_pc <= fetch_pc;
            fetch_pc <= bus.redirect ? bus.redirect_pc : issue ? fetch_pc + 32'd1 : fetch_pc;
        end

    assign incoming = '{pc: pending_pc, insn: bus.q_imem};

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass         = (count == '0) && pending;
    assign bus.insn_valid = (count != '0) || bypass;
    assign cur            = bypass ? incoming : head;
    assign push           = pending && !bus.redirect && !(bypass && bus.insn_ready);
`else
    assign bus.insn_valid = count != '0;
    assign cur            = head;
    assign push           = pending && !bus.redirect;
`endif

    // A flush discards the head rather than popping it.
    assign fifo_pop         = (count != '0) && bus.insn_ready && !bus.redirect;
    assign bus.insn_out     = bus.insn_valid ? cur.insn : NOP_INSN;
    assign bus.insn_pc      = bus.insn_valid ? cur.pc : 32'd0;
    assign bus.address_imem = fetch_pc;

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (fifo_pop),
        .flush (bus.redirect),
        .din   (incoming),
        .head  (head),
        .count (count)
    );
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: directed checks of streaming, back-pressure, redirect, wrap and reset.
module tb_instr_prefetch;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [2:0] count_a, count_b;
    int checks = 0;
    int errors = 0;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    instr_prefetch_if bus_a ();
    instr_prefetch_if bus_b ();

    instr_prefetch #(.DEPTH(4), .RESET_PC(32'd0)) dut_a (
        .clock (clock), .reset (reset), .bus (bus_a), .count (count_a)
    );
    instr_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFE)) dut_b (
        .clock (clock), .reset (reset), .bus (bus_b), .count (count_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        bus_a.q_imem <= bus_a.address_imem + 32'd100;
        bus_b.q_imem <= bus_b.address_imem + 32'd100;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic restart(input logic ready);
        reset = 1'b0;
        bus_a.insn_ready = ready;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        bus_a.redirect = 1'b0;
        bus_a.redirect_pc = '0;
        bus_a.insn_ready = 1'b1;
        bus_b.redirect = 1'b0;
        bus_b.redirect_pc = '0;
        bus_b.insn_ready = 1'b1;
        tick();
        check("rst_addr", bus_a.address_imem, 32'd0);
        check("rst_valid", 32'(bus_a.insn_valid), 32'd0);
        check("rst_insn", bus_a.insn_out, 32'd0);
        check("rst_pc", bus_a.insn_pc, 32'd0);
        check("rst_count", 32'(count_a), 32'd0);
        check("rst_addr_b", bus_b.address_imem, 32'hFFFF_FFFE);
        reset = 1'b1;
        // Streaming at one per cycle; dut_b also covers 32-bit pc wrap.
        for (int i = 1; i < LAT; i++) begin
            tick();
            check("lat_valid", 32'(bus_a.insn_valid), 32'd0);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            check("str_valid", 32'(bus_a.insn_valid), 32'd1);
            check("str_pc", bus_a.insn_pc, 32'(k));
            check("str_insn", bus_a.insn_out, 32'(k + 100));
            if (k < 4) begin
                check("wrap_pc", bus_b.insn_pc, 32'hFFFF_FFFE + 32'(k));
                check("wrap_insn", bus_b.insn_out, 32'hFFFF_FFFE + 32'(k) + 32'd100);
            end
        end
        // Back-pressure: the FIFO fills and fetch stalls without losing entries.
        restart(1'b0);
        repeat (10) tick();
        check("bp_count", 32'(count_a), 32'd4);
        check("bp_addr", bus_a.address_imem, 32'd4);
        check("bp_head", bus_a.insn_pc, 32'd0);
        bus_a.insn_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_pc", bus_a.insn_pc, 32'(k));
            check("bp_insn", bus_a.insn_out, 32'(k + 100));
            tick();
        end
        // Redirect with count=3 and a word in flight.
        restart(1'b0);
        repeat (4) tick();
        check("rd_count3", 32'(count_a), 32'd3);
        bus_a.redirect = 1'b1;
        bus_a.redirect_pc = 32'h40;
        bus_a.insn_ready = 1'b1;
        tick();
        bus_a.redirect = 1'b0;
        check("rd_count0", 32'(count_a), 32'd0);
        check("rd_valid0", 32'(bus_a.insn_valid), 32'd0);
        check("rd_addr", bus_a.address_imem, 32'h40);
        for (int i = 1; i < LAT; i++) begin
            tick();
            check("rd_lat", 32'(bus_a.insn_valid), 32'd0);
        end
        tick();
        check("rd_valid", 32'(bus_a.insn_valid), 32'd1);
        check("rd_pc", bus_a.insn_pc, 32'h40);
        check("rd_insn", bus_a.insn_out, 32'hA4);
        tick();
        check("rd_pc_next", bus_a.insn_pc, 32'h41);
        // Asynchronous reset mid-stream.
        restart(1'b0);
        repeat (3) tick();
        check("ar_count2", 32'(count_a), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("ar_valid", 32'(bus_a.insn_valid), 32'd0);
        check("ar_insn", bus_a.insn_out, 32'd0);
        check("ar_pc", bus_a.insn_pc, 32'd0);
        check("ar_count", 32'(count_a), 32'd0);
        check("ar_addr", bus_a.address_imem, 32'd0);
        bus_a.insn_ready = 1'b1;
        tick();
        reset = 1'b1;
        repeat (LAT) tick();
        check("ar_restart_pc", bus_a.insn_pc, 32'd0);
        check("ar_restart_insn", bus_a.insn_out, 32'd100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
